// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and helpers for the serial pattern detector.
//   state_t  : detector state encoding
//   len_mask : builds a low-order mask of 'len' ones (len in 0..32)
package seq_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  localparam int unsigned MASK_W = 32;

  typedef logic [MASK_W:0] wide_mask_t;

  // One extra bit of headroom so len == 32 yields all ones without overflow.
  function automatic logic [MASK_W-1:0] len_mask(input logic [5:0] len);
    wide_mask_t m;
    m = (wide_mask_t'(1) << len) - wide_mask_t'(1);
    return m[MASK_W-1:0];
  endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock and synchronous active-high reset
//   clr        : clear; a coincident inc leaves the count at 1
//   inc        : increment, sticks at all ones
//   cnt        : registered count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Run-time programmable serial bit-pattern detector.
//   clk, reset   : clock, synchronous active-high reset
//   cfg_load     : latch cfg_pattern / cfg_len / cfg_overlap (illegal len -> cfg_err)
//   cfg_pattern  : pattern, bit [cfg_len-1] received first
//   cfg_len      : pattern length, legal 1..MAX_LEN
//   cfg_overlap  : 1 = overlapping matches, 0 = restart history after a match
//   bit_valid    : qualifies bit_in
//   bit_in       : serial data
//   count_clr    : clears match_count
//   match        : registered one-cycle match pulse
//   match_count  : saturating match counter
//   cfg_err      : registered one-cycle pulse on an illegal load
//   armed        : registered, high while history holds pat_len bits
module seq_pattern_detector
  import seq_detect_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 8,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic               count_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  state_t             state, state_n;
  logic [MAX_LEN-1:0] pat, pat_n;
  logic [LEN_W-1:0]   pat_len, pat_len_n;
  logic               overlap, overlap_n;
  logic [MAX_LEN-1:0] hist, hist_n;
  logic [LEN_W-1:0]   fill, fill_n;
  logic               match_n, cfg_err_n, armed_n;

  logic               cfg_legal_c;
  logic               accept_c;
  logic               hit_c;
  logic [MAX_LEN-1:0] hist_shift_c;
  logic [LEN_W-1:0]   fill_inc_c;
  logic [MAX_LEN-1:0] mask_c;

  // Next-state, compare and output decode.
  always_comb begin
    state_n   = state;
    pat_n     = pat;
    pat_len_n = pat_len;
    overlap_n = overlap;
    hist_n    = hist;
    fill_n    = fill;
    match_n   = 1'b0;
    cfg_err_n = 1'b0;

    cfg_legal_c  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    accept_c     = bit_valid && (state != ST_IDLE) && !cfg_load;
    hist_shift_c = {hist[MAX_LEN-2:0], bit_in};
    // fill never exceeds pat_len, so fill + 1 cannot wrap.
    fill_inc_c   = (fill >= pat_len) ? pat_len : fill + LEN_W'(1);
    mask_c       = MAX_LEN'(len_mask(6'(pat_len)));
    hit_c        = accept_c && (fill_inc_c == pat_len) &&
                   (((hist_shift_c ^ pat) & mask_c) == '0);

    if (cfg_load) begin
      if (cfg_legal_c) begin
        pat_n     = cfg_pattern;
        pat_len_n = cfg_len;
        overlap_n = cfg_overlap;
        hist_n    = '0;
        fill_n    = '0;
        state_n   = ST_HUNT;
      end else begin
        cfg_err_n = 1'b1;
      end
    end else if (accept_c) begin
      match_n = hit_c;
      if (hit_c && !overlap) begin
        hist_n  = '0;
        fill_n  = '0;
        state_n = ST_HUNT;
      end else begin
        hist_n  = hist_shift_c;
        fill_n  = fill_inc_c;
        state_n = (fill_inc_c == pat_len) ? ST_ARMED : ST_HUNT;
      end
    end

    armed_n = (state_n == ST_ARMED);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pat     <= '0;
      pat_len <= '0;
      overlap <= 1'b0;
      hist    <= '0;
      fill    <= '0;
      match   <= 1'b0;
      cfg_err <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_n;
      pat     <= pat_n;
      pat_len <= pat_len_n;
      overlap <= overlap_n;
      hist    <= hist_n;
      fill    <= fill_n;
      match   <= match_n;
      cfg_err <= cfg_err_n;
      armed   <= armed_n;
    end
  end

  // Counter increments on the same edge that registers the match pulse.
  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (count_clr),
    .inc   (hit_c),
    .cnt   (match_count)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed self-checking bench for seq_pattern_detector (MAX_LEN=8, CNT_W=2).
module tb_seq_pattern_detector;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned LEN_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               bit_valid;
  logic               bit_in;
  logic               count_clr;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               armed;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .count_clr   (count_clr),
    .match       (match),
    .match_count (match_count),
    .cfg_err     (cfg_err),
    .armed       (armed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One clock with the given bit; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic v, input logic b, input logic clr);
    bit_valid = v;
    bit_in    = b;
    count_clr = clr;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    count_clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] len, input logic ov,
                      input logic v, input logic clr);
    cfg_pattern = p;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    cyc(v, 1'b1, clr);
    cfg_load    = 1'b0;
  endtask

  task automatic bit_chk(input string tag, input logic b, input logic em, input logic ea);
    cyc(1'b1, b, 1'b0);
    chk({tag, "_match"}, 32'(match), 32'(em));
    chk({tag, "_armed"}, 32'(armed), 32'(ea));
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    bit_valid = 1'b0; bit_in = 1'b0; count_clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_match",   32'(match),       32'd0);
    chk("rst_count",   32'(match_count), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err),     32'd0);
    chk("rst_armed",   32'(armed),       32'd0);
    chk("rst_state",   32'(dut.state),   32'd0);

    // Idle ignores bits.
    cyc(1'b1, 1'b1, 1'b0);
    chk("idle_match", 32'(match), 32'd0);

    // 11011 overlapping: matches after bit 5 and bit 8.
    load(8'h1B, 4'd5, 1'b1, 1'b0, 1'b0);
    chk("ov_load_armed", 32'(armed), 32'd0);
    chk("ov_load_state", 32'(dut.state), 32'd1);
    bit_chk("ov_b1", 1'b1, 1'b0, 1'b0);
    bit_chk("ov_b2", 1'b1, 1'b0, 1'b0);
    bit_chk("ov_b3", 1'b0, 1'b0, 1'b0);
    bit_chk("ov_b4", 1'b1, 1'b0, 1'b0);
    bit_chk("ov_b5", 1'b1, 1'b1, 1'b1);
    bit_chk("ov_b6", 1'b0, 1'b0, 1'b1);
    bit_chk("ov_b7", 1'b1, 1'b0, 1'b1);
    bit_chk("ov_b8", 1'b1, 1'b1, 1'b1);
    chk("ov_count", 32'(match_count), 32'd2);

    // 11011 non-overlapping, leading 0 so armed rises before the match and drops after.
    cyc(1'b0, 1'b0, 1'b1);
    chk("clr_count", 32'(match_count), 32'd0);
    load(8'h1B, 4'd5, 1'b0, 1'b0, 1'b0);
    bit_chk("no_b0", 1'b0, 1'b0, 1'b0);
    bit_chk("no_b1", 1'b1, 1'b0, 1'b0);
    bit_chk("no_b2", 1'b1, 1'b0, 1'b0);
    bit_chk("no_b3", 1'b0, 1'b0, 1'b0);
    bit_chk("no_b4", 1'b1, 1'b0, 1'b1);
    bit_chk("no_b5", 1'b1, 1'b1, 1'b0);
    bit_chk("no_b6", 1'b0, 1'b0, 1'b0);
    bit_chk("no_b7", 1'b1, 1'b0, 1'b0);
    bit_chk("no_b8", 1'b1, 1'b0, 1'b0);
    chk("no_count", 32'(match_count), 32'd1);
    chk("no_state", 32'(dut.state), 32'd1);

    // A5, full length, with a 3-cycle valid gap mid-stream.
    load(8'hA5, 4'd8, 1'b1, 1'b0, 1'b1);
    chk("a5_count0", 32'(match_count), 32'd0);
    bit_chk("a5_b1", 1'b1, 1'b0, 1'b0);
    bit_chk("a5_b2", 1'b0, 1'b0, 1'b0);
    bit_chk("a5_b3", 1'b1, 1'b0, 1'b0);
    bit_chk("a5_b4", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk("a5_gap_match", 32'(match), 32'd0);
    end
    chk("a5_gap_fill", 32'(dut.fill), 32'd4);
    bit_chk("a5_b5", 1'b0, 1'b0, 1'b0);
    bit_chk("a5_b6", 1'b1, 1'b0, 1'b0);
    bit_chk("a5_b7", 1'b0, 1'b0, 1'b0);
    bit_chk("a5_b8", 1'b1, 1'b1, 1'b1);
    chk("a5_count", 32'(match_count), 32'd1);

    // Illegal lengths 0 and 9: cfg_err pulses, old config and state survive.
    load(8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("ill0_err",   32'(cfg_err), 32'd1);
    chk("ill0_armed", 32'(armed),   32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ill0_err_clr", 32'(cfg_err), 32'd0);
    load(8'hFF, 4'd9, 1'b0, 1'b0, 1'b0);
    chk("ill9_err", 32'(cfg_err), 32'd1);
    bit_chk("old_b1", 1'b1, 1'b0, 1'b1);
    chk("ill9_err_clr", 32'(cfg_err), 32'd0);
    bit_chk("old_b2", 1'b0, 1'b0, 1'b1);
    bit_chk("old_b3", 1'b1, 1'b0, 1'b1);
    bit_chk("old_b4", 1'b0, 1'b0, 1'b1);
    bit_chk("old_b5", 1'b0, 1'b0, 1'b1);
    bit_chk("old_b6", 1'b1, 1'b0, 1'b1);
    bit_chk("old_b7", 1'b0, 1'b0, 1'b1);
    bit_chk("old_b8", 1'b1, 1'b1, 1'b1);
    chk("old_count", 32'(match_count), 32'd2);

    // Pattern 1, len 1: load discards the coincident bit; count saturates at 3.
    load(8'h01, 4'd1, 1'b1, 1'b1, 1'b1);
    chk("sat_load_match", 32'(match),       32'd0);
    chk("sat_load_armed", 32'(armed),       32'd0);
    chk("sat_load_count", 32'(match_count), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      bit_chk("sat_bit", 1'b1, 1'b1, 1'b1);
      chk("sat_count", 32'(match_count), (i > 3) ? 32'd3 : 32'(i));
    end
    bit_chk("sat_zero", 1'b0, 1'b0, 1'b1);
    chk("sat_hold", 32'(match_count), 32'd3);
    cyc(1'b1, 1'b1, 1'b1);
    chk("clr_hit_match", 32'(match),       32'd1);
    chk("clr_hit_count", 32'(match_count), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("clr_only_count", 32'(match_count), 32'd0);

    // Reset one bit short of a match; afterwards the detector stays idle.
    load(8'h1B, 4'd5, 1'b1, 1'b0, 1'b0);
    bit_chk("rs_b1", 1'b1, 1'b0, 1'b0);
    bit_chk("rs_b2", 1'b1, 1'b0, 1'b0);
    bit_chk("rs_b3", 1'b0, 1'b0, 1'b0);
    bit_chk("rs_b4", 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    chk("rs_match", 32'(match),       32'd0);
    chk("rs_count", 32'(match_count), 32'd0);
    chk("rs_err",   32'(cfg_err),     32'd0);
    chk("rs_armed", 32'(armed),       32'd0);
    chk("rs_state", 32'(dut.state),   32'd0);
    bit_chk("post_b1", 1'b1, 1'b0, 1'b0);
    bit_chk("post_b2", 1'b1, 1'b0, 1'b0);
    bit_chk("post_b3", 1'b0, 1'b0, 1'b0);
    bit_chk("post_b4", 1'b1, 1'b0, 1'b0);
    bit_chk("post_b5", 1'b1, 1'b0, 1'b0);
    chk("post_count", 32'(match_count), 32'd0);
    chk("post_state", 32'(dut.state),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial bit-pattern detector for the caption and bit-stream front end. It watches a one-bit stream qualified by a valid strobe and matches a run-time programmable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping detection is selectable, and a saturating match counter is provided. With pattern 11011 and overlap enabled, it reproduces the fixed five-state "11011" detector, except that `match` is registered.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- CNT_W, 8: width of the match counter.
- LEN_W, $clog2(MAX_LEN+1): derived width of the length field; not to be overridden.

- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  reset, synchronous and active-high.
- cfg_load  in  1  on a rising clk edge, latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit 0 the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- bit_valid  in  1  qualifies bit_in.
- bit_in  in  1  serial data.
- count_clr  in  1  clears match_count.
- match  out  1  one-cycle pulse; registered.
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  one-cycle pulse when a cfg_load carries an illegal cfg_len.
- armed  out  1  high when configured and the fill count has reached pat_len.

## Operation
- Internal registers:
  - pat, pat_len, overlap: the latched configuration.
  - hist[MAX_LEN-1:0]: shift history.
  - fill[LEN_W-1:0]: saturating count of bits since the last clear.
  - state.
- States:
  - IDLE: no legal config.
  - HUNT: configured, fill < pat_len.
  - ARMED: configured, fill == pat_len.
- Legal cfg_load (cfg_len in 1..MAX_LEN):
  - latch the config; clear hist and fill;
  - go to HUNT.
- Illegal cfg_load:
  - keep the previous config and state unchanged;
  - pulse cfg_err.
- Accepted bit (bit_valid=1, state≠IDLE, no cfg_load):
  - hist_n = {hist[MAX_LEN-2:0], bit_in};
  - fill_n = min(fill+1, pat_len).
- Match condition: fill_n == pat_len and hist_n[pat_len-1:0] == pat[pat_len-1:0]. Bits at or above pat_len are masked from the compare.
- On a match:
  - match is 1 on the next cycle;
  - match_count increments and saturates at 2^CNT_W-1;
  - overlap=1: hist and fill update normally, so the state stays ARMED;
  - overlap=0: hist and fill clear to 0, so the state returns to HUNT.
- State transitions:
  - HUNT→ARMED when fill_n reaches pat_len without a non-overlap clear;
  - ARMED stays ARMED except on a non-overlap match or a cfg_load.
- bit_valid=0: hist, fill, state and count all hold; match=0.
- IDLE ignores bit_valid. match stays 0.
- Simultaneous events:
  - cfg_load with bit_valid: the load wins and the bit is discarded.
  - count_clr with a match: match_count becomes 1.
  - count_clr alone: match_count becomes 0.
  - cfg_load does not clear match_count.
- reset: overrides everything.

## Timing
- Reset values:
  - match=0, match_count=0, cfg_err=0, armed=0;
  - state=IDLE;
  - pat=0, pat_len=0, overlap=0, hist=0, fill=0.
- Latency:
  - the match pulse appears exactly 1 cycle after the edge that samples the last pattern bit;
  - match_count updates on that same edge.
- First match after a load needs at least pat_len accepted bits.
- cfg_err: asserts 1 cycle after an illegal load, for 1 cycle.
- armed: registered; reflects the state after the edge.
- Throughput: one bit per cycle. Back-to-back matches are possible when overlap=1 and the pattern is periodic (e.g. pattern 1, len 1).
- Reset mid-stream: the next edge with reset=1 clears everything. A match pending in the same cycle is lost. A new cfg_load is required afterwards.

## Structure
- Package seq_detect_pkg holds:
  - the state enum (ST_IDLE=2'd0, ST_HUNT=2'd1, ST_ARMED=2'd2);
  - a helper function building the length mask from pat_len.
- Sub-module sat_counter (parameter W; inputs clr, inc; output cnt) implements match_count with the clear/increment priority above.
- Everything else lives in one module: a sequential always block plus a combinational next-state/compare block.

## Test plan
- 11011 regression: load pattern 5'b11011, len 5, overlap=1; send 1,1,0,1,1,0,1,1 → match pulses one cycle after bit 5 and after bit 8; match_count=2.
- Non-overlap: same pattern with overlap=0, same stream → single match after bit 5; match_count=1; armed drops the cycle after the match.
- Gaps and maximum length: MAX_LEN=8, pattern 8'hA5, len 8; stream 10100101 with bit_valid deasserted for 3 cycles mid-stream → one match; no match while bit_valid=0.
- Illegal config: after a legal load, cfg_load with len 0 and then len 9 → cfg_err pulses twice; the old pattern still matches.
- Saturation and clear: CNT_W=2, pattern 1, len 1, overlap=1; send 5 ones → count sticks at 3; count_clr coincident with a match → count=1.
- Reset mid-stream: reset asserted after 4 of 5 pattern bits → all outputs 0 and state IDLE; bits ignored until a cfg_load.
